// File: rtl/huffman_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : huffman_decoder_if
// Purpose  : Codebook, bitstream and symbol signals of the Huffman decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface huffman_decoder_if #(
    parameter int CNT_W = 16
);
    logic             code_valid;
    logic [7:0]       HC1, HC2, HC3, HC4, HC5, HC6;
    logic [7:0]       M1, M2, M3, M4, M5, M6;
    logic             bit_valid;
    logic             bit_in;
    logic             bit_ready;
    logic             sym_valid;
    logic [2:0]       sym;
    logic             err;
    logic [CNT_W-1:0] sym_cnt;

    modport master (
        output code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
        output M1, M2, M3, M4, M5, M6, bit_valid, bit_in,
        input  bit_ready, sym_valid, sym, err, sym_cnt
    );

    modport slave (
        input  code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
        input  M1, M2, M3, M4, M5, M6, bit_valid, bit_in,
        output bit_ready, sym_valid, sym, err, sym_cnt
    );
endinterface
`default_nettype wire

// File: rtl/huffman_decoder.sv
`default_nettype none
// ============================================================================
// Module   : huffman_decoder
// Purpose  : Serial Huffman bitstream decoder, six symbols, codes up to 8 bits.
// Revision : 1.0 - initial release
// ============================================================================
module huffman_decoder #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    huffman_decoder_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DECODE = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       hc_q [6];
    logic [7:0]       m_q  [6];
    logic [3:0]       ln_q [6];
    logic [7:0]       acc_q, acc_d;
    logic [3:0]       len_q, len_d;
    logic             sym_valid_q, sym_valid_d;
    logic [2:0]       sym_q, sym_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0]       w_hc [6];
    logic [7:0]       w_m  [6];
    logic             w_ready;
    logic             w_accept;
    logic [7:0]       w_nacc;
    logic [3:0]       w_nlen;
    logic             w_hit;
    logic [2:0]       w_hit_sym;

    assign w_hc[0] = bus.HC1;  assign w_m[0] = bus.M1;
    assign w_hc[1] = bus.HC2;  assign w_m[1] = bus.M2;
    assign w_hc[2] = bus.HC3;  assign w_m[2] = bus.M3;
    assign w_hc[3] = bus.HC4;  assign w_m[3] = bus.M4;
    assign w_hc[4] = bus.HC5;  assign w_m[4] = bus.M5;
    assign w_hc[5] = bus.HC6;  assign w_m[5] = bus.M6;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < 8; k++) n = n + {3'd0, v[k]};
        return n;
    endfunction

    // A reload request takes priority over the bit offered in the same cycle.
    assign w_ready  = (state_q == DECODE) && !bus.code_valid;
    assign w_accept = w_ready && bus.bit_valid;
    assign w_nacc   = {acc_q[6:0], bus.bit_in};
    assign w_nlen   = len_q + 4'd1;

    // Scanning downward leaves the lowest matching index as the winner.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_sym = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (ln_q[i] != 4'd0 && ln_q[i] == w_nlen && (w_nacc & m_q[i]) == hc_q[i]) begin
                w_hit     = 1'b1;
                w_hit_sym = 3'(i + 1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        len_d       = len_q;
        sym_valid_d = 1'b0;
        sym_d       = sym_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.code_valid) state_d = LOAD;
            end
            LOAD: begin
                acc_d   = 8'd0;
                len_d   = 4'd0;
                cnt_d   = '0;
                state_d = DECODE;
                if (bus.code_valid) state_d = LOAD;
            end
            DECODE: begin
                if (bus.code_valid) begin
                    state_d = LOAD;
                end else if (w_accept) begin
                    if (w_hit) begin
                        sym_valid_d = 1'b1;
                        sym_d       = w_hit_sym;
                        cnt_d       = cnt_q + CNT_W'(1);
                        acc_d       = 8'd0;
                        len_d       = 4'd0;
                    end else if (w_nlen == 4'd8) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                        acc_d   = 8'd0;
                        len_d   = 4'd0;
                    end else begin
                        acc_d = w_nacc;
                        len_d = w_nlen;
                    end
                end
            end
            ERR: begin
                if (bus.code_valid) begin
                    state_d = LOAD;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                hc_q[i] <= 8'd0;
                m_q[i]  <= 8'd0;
                ln_q[i] <= 4'd0;
            end
        end else if (bus.code_valid) begin
            for (int i = 0; i < 6; i++) begin
                hc_q[i] <= w_hc[i];
                m_q[i]  <= w_m[i];
                ln_q[i] <= popcount8(w_m[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= 8'd0;
            len_q       <= 4'd0;
            sym_valid_q <= 1'b0;
            sym_q       <= 3'd0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            sym_valid_q <= sym_valid_d;
            sym_q       <= sym_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.bit_ready = w_ready;
    assign bus.sym_valid = sym_valid_q;
    assign bus.sym       = sym_q;
    assign bus.err       = err_q;
    assign bus.sym_cnt   = cnt_q;
endmodule
`default_nettype wire
